// File: rtl/mem_responder.sv
// mem_responder: word-addressed unified instruction/data memory for the
// multicycle core. Serves one request at a time, inserts LATENCY wait
// cycles, then commits the write or returns the read with a one-cycle
// ready pulse. Misaligned and out-of-range accesses get err instead of
// touching the array.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT  = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] LOADCNT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          lat_we;
  logic [31:0]   lat_adr;
  logic [31:0]   lat_data;

  logic          acc_we;
  logic [31:0]   acc_adr;
  logic [31:0]   acc_data;
  logic          enter_resp;
  logic          err_cond;
  logic [AW-1:0] idx;

  // The array is deliberately left out of reset so program/data contents
  // survive a core reset.
  logic [31:0]   mem [DEPTH_WORDS];

  // Select the fields of the access being performed on this edge. With
  // LATENCY=0 the access happens on the acceptance edge itself, so the live
  // inputs are used instead of the (not yet loaded) latched copies.
  always_comb begin
    acc_we     = lat_we;
    acc_adr    = lat_adr;
    acc_data   = lat_data;
    enter_resp = 1'b0;
    if (state == IDLE) begin
      acc_we     = we;
      acc_adr    = Adr;
      acc_data   = WriteData;
      enter_resp = req && (LATENCY == 0);
    end else if (state == WAIT) begin
      enter_resp = (cnt == 4'd1);
    end
  end

  assign err_cond = (acc_adr[1:0] != 2'b00) || ({1'b0, acc_adr} >= LIMIT);
  assign idx      = acc_adr[AW+1:2];

  // Commit a good write on the edge that enters RESP; gated by reset so an
  // edge during reset can never write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && acc_we && !err_cond) begin
      mem[idx] <= acc_data;
    end
  end

  // Control FSM with registered ready/err/busy/ReadData.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_we   <= 1'b0;
      lat_adr  <= 32'h0;
      lat_data <= 32'h0;
      ready    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      ReadData <= 32'h0;
    end else begin
      ready <= enter_resp;
      err   <= enter_resp && err_cond;

      if (enter_resp) begin
        if (err_cond) begin
          ReadData <= 32'h0;
        end else if (!acc_we) begin
          ReadData <= mem[idx];
        end
      end

      case (state)
        IDLE: begin
          if (req) begin
            lat_we   <= we;
            lat_adr  <= Adr;
            lat_data <= WriteData;
            cnt      <= LOADCNT;
            busy     <= 1'b1;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        WAIT: begin
          cnt  <= cnt - 4'd1;
          busy <= 1'b1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with LATENCY=2 carries
// most of the sequence, a second with LATENCY=0 covers the zero-wait path.
module tb_mem_responder;

  logic        clk;
  logic        reset;

  logic        req2, we2;
  logic [31:0] adr2, wd2, rd2;
  logic        rdy2, err2, busy2;

  logic        req0, we0;
  logic [31:0] adr0, wd0, rd0;
  logic        rdy0, err0, busy0;

  int total;
  int bad;

  int          lat;
  logic [31:0] rdv;
  logic        erv;
  logic        saw_ready;
  logic [5:0]  pattern;

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .Adr(adr2),
    .WriteData(wd2), .ReadData(rd2), .ready(rdy2), .err(err2), .busy(busy2)
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .Adr(adr0),
    .WriteData(wd0), .ReadData(rd0), .ready(rdy0), .err(err0), .busy(busy0)
  );

  // 10-unit clock; stimulus and sampling happen on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request to the LATENCY=2 instance with req held a single
  // cycle; return the cycle count to ready plus the response values.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               output int cycles, output logic [31:0] rdata, output logic e);
    @(negedge clk);
    req2 = 1'b1; we2 = w; adr2 = a; wd2 = d;
    @(negedge clk);
    req2 = 1'b0;
    cycles = 1;
    while (!rdy2 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    rdata = rd2;
    e     = err2;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    req2 = 0; we2 = 0; adr2 = 0; wd2 = 0;
    req0 = 0; we0 = 0; adr0 = 0; wd0 = 0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_ready", rdy2, 0);
    checkOutput("rst_err", err2, 0);
    checkOutput("rst_busy", busy2, 0);
    checkOutput("rst_rdata", rd2, 32'h0);
    checkOutput("rst_ready0", rdy0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Write then read 0x10, ready 3 cycles after acceptance
    applyStimulus(1'b1, 32'h10, 32'hCAFEF00D, lat, rdv, erv);
    checkOutput("wr10_lat", lat, 3);
    checkOutput("wr10_err", erv, 0);
    checkOutput("wr10_busy_resp", busy2, 1);
    @(negedge clk);
    checkOutput("wr10_ready_drop", rdy2, 0);
    checkOutput("wr10_busy_drop", busy2, 0);
    applyStimulus(1'b0, 32'h10, 32'h0, lat, rdv, erv);
    checkOutput("rd10_lat", lat, 3);
    checkOutput("rd10_data", rdv, 32'hCAFEF00D);
    checkOutput("rd10_err", erv, 0);
    @(negedge clk);
    checkOutput("rd10_err_drop", err2, 0);

    // Error accesses: misaligned read and out-of-range write aliasing word 0
    applyStimulus(1'b1, 32'h0, 32'h5A5A0000, lat, rdv, erv);
    checkOutput("wr0_err", erv, 0);
    applyStimulus(1'b0, 32'h6, 32'h0, lat, rdv, erv);
    checkOutput("mis_lat", lat, 3);
    checkOutput("mis_err", erv, 1);
    checkOutput("mis_rdata", rdv, 32'h0);
    applyStimulus(1'b0, 32'h10, 32'h0, lat, rdv, erv);
    checkOutput("rd10_again", rdv, 32'hCAFEF00D);
    applyStimulus(1'b1, 32'h100, 32'hDEADDEAD, lat, rdv, erv);
    checkOutput("oor_err", erv, 1);
    checkOutput("oor_rdata", rdv, 32'h0);
    @(negedge clk);
    checkOutput("oor_err_drop", err2, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, lat, rdv, erv);
    checkOutput("word0_kept", rdv, 32'h5A5A0000);
    checkOutput("word0_err", erv, 0);

    // Hold req and change Adr during WAIT; response uses latched 0x10
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b0; adr2 = 32'h10;
    @(negedge clk);
    adr2 = 32'h0;
    checkOutput("hold_busy_w1", busy2, 1);
    checkOutput("hold_ready_w1", rdy2, 0);
    @(negedge clk);
    adr2 = 32'h4;
    checkOutput("hold_busy_w2", busy2, 1);
    checkOutput("hold_ready_w2", rdy2, 0);
    @(negedge clk);
    checkOutput("hold_ready_resp", rdy2, 1);
    checkOutput("hold_busy_resp", busy2, 1);
    checkOutput("hold_rdata", rd2, 32'hCAFEF00D);
    req2 = 1'b0;
    @(negedge clk);
    checkOutput("hold_idle_busy", busy2, 0);
    checkOutput("hold_idle_ready", rdy2, 0);

    // Reset in the middle of WAIT aborts a write to 0x20
    applyStimulus(1'b1, 32'h20, 32'h11112222, lat, rdv, erv);
    checkOutput("wr20_lat", lat, 3);
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; adr2 = 32'h20; wd2 = 32'hAAAA5555;
    @(negedge clk);
    req2 = 1'b0;
    checkOutput("abort_busy_before", busy2, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_ready", rdy2, 0);
    checkOutput("abort_busy", busy2, 0);
    checkOutput("abort_err", err2, 0);
    checkOutput("abort_rdata", rd2, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw_ready = saw_ready | rdy2;
    end
    checkOutput("abort_no_ready", saw_ready, 0);
    applyStimulus(1'b0, 32'h20, 32'h0, lat, rdv, erv);
    checkOutput("abort_mem_kept", rdv, 32'h11112222);

    // Memory survives reset after a completed write
    applyStimulus(1'b1, 32'h3C, 32'h0BADBEEF, lat, rdv, erv);
    checkOutput("wr3c_err", erv, 0);
    @(negedge clk);
    reset = 1'b1;
    #3 reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_rdata", rd2, 32'h0);
    applyStimulus(1'b0, 32'h3C, 32'h0, lat, rdv, erv);
    checkOutput("rd3c_after_rst", rdv, 32'h0BADBEEF);

    // LATENCY=0: ready the cycle after acceptance
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h0; wd0 = 32'h12345678;
    @(negedge clk);
    req0 = 1'b0;
    checkOutput("l0_wr_ready", rdy0, 1);
    checkOutput("l0_wr_busy", busy0, 1);
    @(negedge clk);
    checkOutput("l0_wr_ready_drop", rdy0, 0);

    // LATENCY=0 with req held: one accepted request every 2 cycles
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'h0;
    pattern = 6'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pattern = {pattern[4:0], rdy0};
      if (i == 0) begin
        checkOutput("l0_rd_data", rd0, 32'h12345678);
        checkOutput("l0_rd_err", err0, 0);
      end
    end
    req0 = 1'b0;
    checkOutput("l0_ready_pattern", pattern, 6'b101010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #20000;
    bad++;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed unified instruction/data memory that serves the multicycle core's memory port (Adr / WriteData / ReadData).
- Accepts one request at a time.
- Inserts a parameterised number of wait states, then commits the write or returns the read with a one-cycle ready pulse.
- Flags misaligned and out-of-range accesses.
- Sits between the core's address/write-data outputs and its instruction and data registers; the controller stalls until ready.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, at least 2.
- LATENCY, 2, wait cycles inserted between request acceptance and response; range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- Adr  input  32  byte address; sampled with req.
- WriteData  input  32  write data; sampled with req.
- ReadData  output  32  registered read data.
- ready  output  1  one-cycle response pulse.
- err  output  1  access error; valid only while ready=1.
- busy  output  1  high in WAIT and RESP; request not accepted.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, wait counter=0, ready=0, err=0, busy=0, ReadData=32'h0.
  - Latched request fields are cleared.
  - Memory array is not cleared; contents survive reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On a rising edge with req=1, latch we/Adr/WriteData and load counter=LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
  - With req=0, stay in IDLE.
- WAIT:
  - Counter decrements by 1 each cycle.
  - On the edge where counter==1, go to RESP.
  - req is ignored in WAIT.
- Entry to RESP (the edge that enters RESP) performs the access:
  - Word index = latched Adr[log2(DEPTH_WORDS)+1:2].
  - err_cond = (Adr[1:0]!=2'b00) OR (Adr >= 4*DEPTH_WORDS).
  - Write with !err_cond: mem[index] <= WriteData; ReadData unchanged.
  - Read with !err_cond: ReadData <= mem[index].
  - err_cond: no memory update; ReadData <= 32'h0; err <= 1.
- RESP:
  - ready=1 and busy=1 for exactly one cycle, then IDLE.
  - req is ignored in RESP; it is re-sampled from the first IDLE cycle.
- Latency: acceptance edge to ready-high is LATENCY+1 cycles. Back-to-back accesses therefore cost LATENCY+2 cycles each.
- err and ready are both registered; err returns to 0 on the edge leaving RESP.
- ReadData holds its value until the next successful read or error response.
- Read-after-write to the same word returns the newly written data; there is no bypass hazard because accesses are serialised.
- Reset during WAIT aborts the access: no memory write occurs and no ready pulse is produced. A write already committed on RESP entry remains.
- Changes to Adr, WriteData, we or req after acceptance have no effect on the in-flight access.
- Counter width is 4 bits; LATENCY=0 never enters WAIT.

Test Plan:
- LATENCY=2: write 32'hCAFEF00D to Adr 0x10 (req held 1 cycle), then read 0x10.
  - Required: ready pulses exactly 3 cycles after each acceptance.
  - Required: the read returns ReadData=32'hCAFEF00D, err=0.
- LATENCY=0: read Adr 0x0 after a write of 32'h12345678.
  - Required: ready in the cycle after acceptance.
  - Required: with req held high continuously, requests are accepted every 2 cycles.
- Misaligned read at Adr 0x6 and out-of-range write at 0x100 (DEPTH_WORDS=64).
  - Required: ready=1 with err=1 and ReadData=0 for both.
  - Required: a subsequent read of 0x100 mod 256 = word 0 shows its previous contents unchanged.
- Hold req=1 and change Adr during WAIT.
  - Required: the response reflects the originally latched address.
  - Required: busy=1 throughout WAIT/RESP.
- Assert reset mid-WAIT of a write of 32'hAAAA5555 to 0x20.
  - Required: all outputs go to 0 immediately and no ready pulse occurs.
  - Required: a later read of 0x20 returns the pre-write contents.
- Reset after a completed write of 32'h0BADBEEF to 0x3C.
  - Required: a read of 0x3C after reset returns 32'h0BADBEEF (memory preserved).
